// File: rtl/axi_rd_protocol_checker.sv
// Passive AXI4 read-channel monitor: handshake stability, timeouts and
// per-ID burst/RLAST tracking through an in-order outstanding table.
module axi_rd_protocol_checker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MAXWAITS        = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic                  chk_en,
    input  logic                  err_clr,
    input  logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic [9:0]            err_pulse,
    output logic [9:0]            err_sticky,
    output logic [CNT_W-1:0]      outstanding_cnt
);

    localparam int IDX_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int WAIT_W = (MAXWAITS > 0) ? $clog2(MAXWAITS + 1) : 1;
    localparam int AR_PW  = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int R_PW   = ID_WIDTH + DATA_WIDTH + 3;

    // Handshake semantics: a transfer happens on a rising edge where valid and
    // ready are both 1; once valid is raised it must stay high with a frozen
    // payload until that edge, and ready may change freely.
    logic             prev_arvalid, prev_arready, prev_rvalid, prev_rready;
    logic [AR_PW-1:0] prev_ar_payload;
    logic [R_PW-1:0]  prev_r_payload;
    logic             first_cycle;

    logic [AR_PW-1:0] ar_payload;
    logic [R_PW-1:0]  r_payload;

    assign ar_payload = {arid, araddr, arlen, arsize, arburst};
    assign r_payload  = {rid, rdata, rresp, rlast};

    logic                tbl_valid [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0] tbl_id    [MAX_OUTSTANDING];
    logic [7:0]          tbl_rem   [MAX_OUTSTANDING];

    logic                nxt_valid [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0] nxt_id    [MAX_OUTSTANDING];
    logic [7:0]          nxt_rem   [MAX_OUTSTANDING];

    logic             ar_hs, r_hs;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [7:0]       hit_rem;
    logic             r_match, r_retire, r_dec, rlast_bad;
    logic [CNT_W-1:0] cnt_after;
    logic             ar_full, ar_insert;
    logic [CNT_W-1:0] cnt_next;
    logic             ar_to, r_to;
    logic [9:0]       err_now;
    logic [9:0]       pulse_next;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // Oldest matching entry wins, which enforces in-order return per ID.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!hit && tbl_valid[i] && (tbl_id[i] == rid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_rem   = tbl_rem[hit_idx];
    assign r_match   = r_hs & hit;
    assign r_retire  = r_match & ((hit_rem == 8'd0) | rlast);
    assign r_dec     = r_match & ~r_retire;
    assign rlast_bad = r_match & (rlast != (hit_rem == 8'd0));
    assign cnt_after = outstanding_cnt - CNT_W'(r_retire);
    assign ar_full   = (cnt_after == CNT_W'(MAX_OUTSTANDING));
    assign ar_insert = ar_hs & ~ar_full;
    assign cnt_next  = cnt_after + CNT_W'(ar_insert);

    // Retire shifts younger entries down first; the insert then lands in the
    // first free slot of the compacted result.
    always_comb begin
        for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            int src;
            src          = (j + 1 < MAX_OUTSTANDING) ? j + 1 : j;
            nxt_valid[j] = tbl_valid[j];
            nxt_id[j]    = tbl_id[j];
            nxt_rem[j]   = tbl_rem[j];
            if (r_retire && (j >= int'(hit_idx))) begin
                if (j + 1 < MAX_OUTSTANDING) begin
                    nxt_valid[j] = tbl_valid[src];
                    nxt_id[j]    = tbl_id[src];
                    nxt_rem[j]   = tbl_rem[src];
                end else begin
                    nxt_valid[j] = 1'b0;
                    nxt_id[j]    = '0;
                    nxt_rem[j]   = '0;
                end
            end else if (r_dec && (j == int'(hit_idx))) begin
                nxt_rem[j] = tbl_rem[j] - 8'd1;
            end
            if (ar_insert && (j == int'(cnt_after))) begin
                nxt_valid[j] = 1'b1;
                nxt_id[j]    = arid;
                nxt_rem[j]   = arlen;
            end
        end
    end

    generate
        if (MAXWAITS > 0) begin : g_timeout
            logic [WAIT_W-1:0] ar_wait, r_wait;

            always_ff @(posedge sig_clock or negedge sig_reset) begin
                if (!sig_reset) begin
                    ar_wait <= '0;
                    r_wait  <= '0;
                end else begin
                    if (arvalid && !arready) begin
                        if (ar_wait != WAIT_W'(MAXWAITS)) ar_wait <= ar_wait + 1'b1;
                    end else begin
                        ar_wait <= '0;
                    end
                    if (rvalid && !rready) begin
                        if (r_wait != WAIT_W'(MAXWAITS)) r_wait <= r_wait + 1'b1;
                    end else begin
                        r_wait <= '0;
                    end
                end
            end

            // Fires only on the step into saturation, so one pulse per stall.
            assign ar_to = arvalid & ~arready & (ar_wait == WAIT_W'(MAXWAITS - 1));
            assign r_to  = rvalid & ~rready & (r_wait == WAIT_W'(MAXWAITS - 1));
        end else begin : g_no_timeout
            assign ar_to = 1'b0;
            assign r_to  = 1'b0;
        end
    endgenerate

    always_comb begin
        err_now    = '0;
        err_now[0] = prev_arvalid & ~prev_arready & ~arvalid;
        err_now[1] = prev_arvalid & ~prev_arready & arvalid & (ar_payload != prev_ar_payload);
        err_now[2] = prev_rvalid & ~prev_rready & ~rvalid;
        err_now[3] = prev_rvalid & ~prev_rready & rvalid & (r_payload != prev_r_payload);
        err_now[4] = r_hs & ~hit;
        err_now[5] = rlast_bad;
        err_now[6] = ar_hs & ar_full;
        err_now[7] = ar_to;
        err_now[8] = r_to;
        err_now[9] = first_cycle & (arvalid | rvalid);
    end

    assign pulse_next = err_now & {10{chk_en}};

    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            prev_arvalid    <= 1'b0;
            prev_arready    <= 1'b0;
            prev_rvalid     <= 1'b0;
            prev_rready     <= 1'b0;
            prev_ar_payload <= '0;
            prev_r_payload  <= '0;
            first_cycle     <= 1'b1;
            err_pulse       <= '0;
            err_sticky      <= '0;
            outstanding_cnt <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_id[i]    <= '0;
                tbl_rem[i]   <= '0;
            end
        end else begin
            prev_arvalid    <= arvalid;
            prev_arready    <= arready;
            prev_rvalid     <= rvalid;
            prev_rready     <= rready;
            prev_ar_payload <= ar_payload;
            prev_r_payload  <= r_payload;
            first_cycle     <= 1'b0;
            err_pulse       <= pulse_next;
            // A new error in the clearing cycle still lands in the sticky vector.
            err_sticky      <= (err_clr ? 10'd0 : err_sticky) | pulse_next;
            outstanding_cnt <= cnt_next;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tbl_valid[i] <= nxt_valid[i];
                tbl_id[i]    <= nxt_id[i];
                tbl_rem[i]   <= nxt_rem[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_protocol_checker.sv
// Directed bench for axi_rd_protocol_checker: legal bursts, RLAST, stalls,
// ID ordering, full table, sticky clear and reset behaviour.
module tb_axi_rd_protocol_checker;

    logic        sig_clock;
    logic        sig_reset;
    logic        chk_en;
    logic        err_clr;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [9:0]  err_pulse;
    logic [9:0]  err_sticky;
    logic [3:0]  outstanding_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    axi_rd_protocol_checker #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4),
        .MAX_OUTSTANDING(8), .MAXWAITS(16), .CNT_W(4)
    ) dut (
        .sig_clock(sig_clock), .sig_reset(sig_reset), .chk_en(chk_en), .err_clr(err_clr),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .err_pulse(err_pulse), .err_sticky(err_sticky), .outstanding_cnt(outstanding_cnt)
    );

    // clock / watchdog
    initial sig_clock = 1'b0;
    always #5 sig_clock = ~sig_clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge sig_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ar_set(input logic v, input logic rdy, input logic [3:0] id,
                          input logic [7:0] len, input logic [31:0] addr);
        arvalid = v; arready = rdy; arid = id; arlen = len; araddr = addr;
        arsize = 3'd3; arburst = 2'd1;
    endtask

    task automatic r_set(input logic v, input logic rdy, input logic [3:0] id, input logic last);
        rvalid = v; rready = rdy; rid = id; rlast = last;
        rdata = {32'hD00D_0000, 28'h0, id}; rresp = 2'd0;
    endtask

    initial begin
        logic [9:0] exp_p;
        sig_reset = 1'b0;
        chk_en = 1'b1; err_clr = 1'b0;
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        r_set(1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) @(posedge sig_clock);
        #1;
        check("reset_pulse", 32'(err_pulse), 32'h0);
        check("reset_sticky", 32'(err_sticky), 32'h0);
        check("reset_cnt", 32'(outstanding_cnt), 32'h0);

        // rvalid high on the first edge after release
        sig_reset = 1'b1;
        tick();
        check("valid_after_reset_pulse", 32'(err_pulse), 32'h200);
        check("valid_after_reset_sticky", 32'(err_sticky), 32'h200);

        // drop stalled rvalid while clearing: set wins over clear
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        err_clr = 1'b1;
        tick();
        check("clr_with_rdrop_pulse", 32'(err_pulse), 32'h004);
        check("clr_with_rdrop_sticky", 32'(err_sticky), 32'h004);
        tick();
        check("clr_idle_sticky", 32'(err_sticky), 32'h000);
        err_clr = 1'b0;

        // legal burst id=3 len=3
        ar_set(1'b1, 1'b1, 4'd3, 8'd3, 32'h1000);
        exp_q.push_back(4'd1);
        tick();
        check("legal_ar_cnt", 32'(outstanding_cnt), 32'(exp_q.pop_front()));
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        exp_q.push_back(4'd1); exp_q.push_back(4'd1); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        for (int b = 0; b < 4; b++) begin
            r_set(1'b1, 1'b1, 4'd3, (b == 3));
            tick();
            check("legal_beat_cnt", 32'(outstanding_cnt), 32'(exp_q.pop_front()));
        end
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check("legal_sticky", 32'(err_sticky), 32'h0);

        // early RLAST: id=1 len=2, rlast on beat 2
        ar_set(1'b1, 1'b1, 4'd1, 8'd2, 32'h2000);
        tick();
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        r_set(1'b1, 1'b1, 4'd1, 1'b0);
        tick();
        check("early_beat1_pulse", 32'(err_pulse), 32'h0);
        r_set(1'b1, 1'b1, 4'd1, 1'b1);
        tick();
        check("early_rlast_pulse", 32'(err_pulse), 32'h020);
        check("early_rlast_cnt", 32'(outstanding_cnt), 32'h0);
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        err_clr = 1'b1;
        tick();
        check("early_rlast_one_cycle", 32'(err_pulse), 32'h0);
        err_clr = 1'b0;

        // 16-cycle AR stall, address changed on the 5th stalled edge
        for (int c = 1; c <= 17; c++) begin
            ar_set(1'b1, 1'b0, 4'd0, 8'd0, (c >= 5) ? 32'h3040 : 32'h3000);
            tick();
            exp_p = (c == 5) ? 10'h002 : (c == 16) ? 10'h080 : 10'h000;
            check($sformatf("stall_c%0d_pulse", c), 32'(err_pulse), 32'(exp_p));
        end
        check("stall_sticky", 32'(err_sticky), 32'h082);
        ar_set(1'b1, 1'b1, 4'd0, 8'd0, 32'h3040);
        tick();
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        r_set(1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stall_drained_cnt", 32'(outstanding_cnt), 32'h0);
        check("stall_cleared_sticky", 32'(err_sticky), 32'h0);

        // different IDs may complete out of order
        ar_set(1'b1, 1'b1, 4'd2, 8'd0, 32'h4000);
        tick();
        ar_set(1'b1, 1'b1, 4'd5, 8'd0, 32'h5000);
        tick();
        check("ooo_cnt2", 32'(outstanding_cnt), 32'h2);
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        r_set(1'b1, 1'b1, 4'd5, 1'b1);
        tick();
        check("ooo_r5_pulse", 32'(err_pulse), 32'h0);
        check("ooo_r5_cnt", 32'(outstanding_cnt), 32'h1);
        r_set(1'b1, 1'b1, 4'd2, 1'b1);
        tick();
        check("ooo_r2_pulse", 32'(err_pulse), 32'h0);
        check("ooo_r2_cnt", 32'(outstanding_cnt), 32'h0);
        r_set(1'b1, 1'b1, 4'd7, 1'b1);
        tick();
        check("unexpected_r7_pulse", 32'(err_pulse), 32'h010);
        check("unexpected_r7_cnt", 32'(outstanding_cnt), 32'h0);

        // chk_en=0 masks the same violation
        chk_en = 1'b0;
        tick();
        check("chk_en_masked_pulse", 32'(err_pulse), 32'h0);
        chk_en = 1'b1;
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // fill the table with ids 0..7
        for (int k = 0; k < 8; k++) begin
            ar_set(1'b1, 1'b1, 4'(k), 8'd0, 32'h6000 + 32'(k));
            tick();
        end
        check("full_cnt", 32'(outstanding_cnt), 32'h8);
        ar_set(1'b1, 1'b1, 4'd9, 8'd0, 32'h6100);
        r_set(1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        check("full_retire_insert_cnt", 32'(outstanding_cnt), 32'h8);
        check("full_retire_insert_pulse", 32'(err_pulse), 32'h0);
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        ar_set(1'b1, 1'b1, 4'd10, 8'd0, 32'h6200);
        tick();
        check("overflow_pulse", 32'(err_pulse), 32'h040);
        check("overflow_cnt", 32'(outstanding_cnt), 32'h8);
        ar_set(1'b0, 1'b0, 4'd0, 8'd0, 32'h0);
        tick();

        // asynchronous reset mid-burst
        #2;
        sig_reset = 1'b0;
        #1;
        check("async_reset_cnt", 32'(outstanding_cnt), 32'h0);
        check("async_reset_sticky", 32'(err_sticky), 32'h0);
        #1;
        sig_reset = 1'b1;
        tick();
        check("post_reset_pulse", 32'(err_pulse), 32'h0);
        r_set(1'b1, 1'b1, 4'd1, 1'b1);
        tick();
        check("post_reset_table_empty", 32'(err_pulse), 32'h010);
        r_set(1'b0, 1'b1, 4'd0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
